pipeline_control_ldst_arbiter: RTL and testbench

//  Shares the single pipeline-control load/store port among REQ_N sequencers (IRQ call, IRQ return, exception save).

---
 rtl/pipeline_control_ldst_arbiter_pkg.sv | 14 +
 rtl/pipeline_control_ldst_arbiter_rr_pick.sv | 36 +++
 rtl/pipeline_control_ldst_arbiter.sv | 165 ++++++++++++++++
 tb/tb_pipeline_control_ldst_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_ldst_arbiter_pkg.sv
// rtl/pipeline_control_ldst_arbiter_pkg.sv - shared encodings for the pipeline-control LDST port arbiter
package pipeline_control_ldst_arbiter_pkg;

    typedef logic [1:0] pl_arb_state_t;

    localparam pl_arb_state_t PL_ARB_IDLE  = 2'h0;
    localparam pl_arb_state_t PL_ARB_LOCK  = 2'h1;
    localparam pl_arb_state_t PL_ARB_DRAIN = 2'h2;

    localparam logic [1:0] LDST_ORDER_BYTE = 2'b00;
    localparam logic [1:0] LDST_ORDER_HALF = 2'b01;
    localparam logic [1:0] LDST_ORDER_WORD = 2'b10;

endpackage

// File: rtl/pipeline_control_ldst_arbiter_rr_pick.sv
// rtl/pipeline_control_ldst_arbiter_rr_pick.sv - combinational round-robin one-hot picker
module pipeline_control_rr_pick #(
    parameter int REQ_N = 3,
    localparam int IW = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [REQ_N-1:0] gnt,
    output logic [IW-1:0]    idx
);

    localparam int SW = IW + 1;

    logic [2*REQ_N-1:0] dbl;
    logic [REQ_N-1:0]   rot;
    logic [SW-1:0]      sum;
    logic               any;

    // Rotate so the pointer position lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[REQ_N-1:0];
        any = |req;
        sum = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (rot[i]) sum = {1'b0, ptr} + SW'(i);
        end
        if (sum >= SW'(REQ_N)) sum = sum - SW'(REQ_N);
        idx = sum[IW-1:0];
        gnt = '0;
        for (int i = 0; i < REQ_N; i++) begin
            gnt[i] = any && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/pipeline_control_ldst_arbiter.sv
// rtl/pipeline_control_ldst_arbiter.sv - locks the single LDST port to one sequencer and routes its responses
module pipeline_control_ldst_arbiter
    import pipeline_control_ldst_arbiter_pkg::*;
#(
    parameter int REQ_N    = 3,
    parameter int OUTS_MAX = 2
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    input  logic                iRESET_SYNC,
    input  logic [REQ_N-1:0]    iRQ_USE,
    input  logic [REQ_N-1:0]    iRQ_REQ,
    output logic [REQ_N-1:0]    oRQ_BUSY,
    output logic [REQ_N-1:0]    oRQ_GNT,
    input  logic [2*REQ_N-1:0]  iRQ_ORDER,
    input  logic [REQ_N-1:0]    iRQ_RW,
    input  logic [14*REQ_N-1:0] iRQ_ASID,
    input  logic [2*REQ_N-1:0]  iRQ_MMUMOD,
    input  logic [32*REQ_N-1:0] iRQ_PDT,
    input  logic [32*REQ_N-1:0] iRQ_ADDR,
    input  logic [32*REQ_N-1:0] iRQ_DATA,
    output logic [REQ_N-1:0]    oRQ_VALID,
    output logic [31:0]         oRQ_DATA,
    output logic                oLDST_USE,
    output logic                oLDST_REQ,
    output logic [1:0]          oLDST_ORDER,
    output logic                oLDST_RW,
    output logic [13:0]         oLDST_ASID,
    output logic [1:0]          oLDST_MMUMOD,
    output logic [31:0]         oLDST_PDT,
    output logic [31:0]         oLDST_ADDR,
    output logic [31:0]         oLDST_DATA,
    input  logic                iLDST_BUSY,
    input  logic                iLDST_REQ,
    input  logic [31:0]         iLDST_DATA
);

    localparam int IW  = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int CW  = $clog2(OUTS_MAX + 1);
    localparam int W2  = $clog2(2 * REQ_N);
    localparam int W14 = $clog2(14 * REQ_N);
    localparam int W32 = $clog2(32 * REQ_N);

    pl_arb_state_t    state;
    logic [REQ_N-1:0] gnt_q;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    rr_ptr;
    logic [CW-1:0]    outs;
    logic [CW-1:0]    outs_next;
    logic             sync_flushed;

    logic [REQ_N-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    rr_next;
    logic             lock;
    logic             full;
    logic             issue;
    logic [W2-1:0]    b2;
    logic [W14-1:0]   b14;
    logic [W32-1:0]   b32;

    pipeline_control_rr_pick #(.REQ_N(REQ_N)) u_rr_pick (
        .req (iRQ_USE),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign lock    = (state == PL_ARB_LOCK);
    assign full    = (outs == CW'(OUTS_MAX));
    assign rr_next = (owner == IW'(REQ_N - 1)) ? '0 : owner + IW'(1);
    assign b2      = W2'(owner) * W2'(2);
    assign b14     = W14'(owner) * W14'(14);
    assign b32     = W32'(owner) * W32'(32);
    assign oRQ_GNT  = gnt_q;
    assign oRQ_DATA = iLDST_DATA;
    assign issue    = oLDST_REQ & ~iLDST_BUSY;

    always_comb begin
        oLDST_USE    = (state != PL_ARB_IDLE);
        oLDST_REQ    = 1'b0;
        oLDST_ORDER  = '0;
        oLDST_RW     = 1'b0;
        oLDST_ASID   = '0;
        oLDST_MMUMOD = '0;
        oLDST_PDT    = '0;
        oLDST_ADDR   = '0;
        oLDST_DATA   = '0;
        oRQ_BUSY     = '1;
        oRQ_VALID    = '0;
        if (lock) begin
            // A full window holds the strobe back so the counter can never pass OUTS_MAX.
            oLDST_REQ       = iRQ_REQ[owner] & ~full;
            oLDST_ORDER     = iRQ_ORDER[b2 +: 2];
            oLDST_RW        = iRQ_RW[owner];
            oLDST_ASID      = iRQ_ASID[b14 +: 14];
            oLDST_MMUMOD    = iRQ_MMUMOD[b2 +: 2];
            oLDST_PDT       = iRQ_PDT[b32 +: 32];
            oLDST_ADDR      = iRQ_ADDR[b32 +: 32];
            oLDST_DATA      = iRQ_DATA[b32 +: 32];
            oRQ_BUSY[owner] = iLDST_BUSY | full;
        end
        if (state != PL_ARB_IDLE) oRQ_VALID[owner] = iLDST_REQ;
    end

    always_comb begin
        outs_next = outs;
        if (issue && !iLDST_REQ)                 outs_next = outs + CW'(1);
        else if (!issue && iLDST_REQ && outs != 0) outs_next = outs - CW'(1);
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state        <= PL_ARB_IDLE;
            gnt_q        <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            outs         <= '0;
            sync_flushed <= 1'b0;
        end else if (iRESET_SYNC) begin
            state        <= PL_ARB_IDLE;
            gnt_q        <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            outs         <= '0;
            sync_flushed <= 1'b1;
        end else begin
            outs <= outs_next;
            case (state)
                PL_ARB_IDLE: begin
                    if (|iRQ_USE) begin
                        state        <= PL_ARB_LOCK;
                        gnt_q        <= pick_gnt;
                        owner        <= pick_idx;
                        sync_flushed <= 1'b0;
                    end
                end
                PL_ARB_LOCK: begin
                    if (!iRQ_USE[owner]) begin
                        if (outs_next != 0) begin
                            state <= PL_ARB_DRAIN;
                        end else begin
                            state  <= PL_ARB_IDLE;
                            gnt_q  <= '0;
                            rr_ptr <= rr_next;
                        end
                    end
                end
                PL_ARB_DRAIN: begin
                    if (outs_next == 0) begin
                        state  <= PL_ARB_IDLE;
                        gnt_q  <= '0;
                        rr_ptr <= rr_next;
                    end
                end
                default: state <= PL_ARB_IDLE;
            endcase
        end
    end

    // Late responses after a sync flush are expected; any other response with no owner is a protocol error.
    a_no_idle_resp: assert property (@(posedge iCLOCK) disable iff (!inRESET || iRESET_SYNC)
        !(state == PL_ARB_IDLE && iLDST_REQ && !sync_flushed));

endmodule

// File: tb/tb_pipeline_control_ldst_arbiter.sv
// tb/tb_pipeline_control_ldst_arbiter.sv - directed self-checking bench for the LDST port arbiter
module tb_pipeline_control_ldst_arbiter;
    import pipeline_control_ldst_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rsync;
    logic [2:0]  use_v, req_v, rw_v;
    logic [5:0]  order_v, mmumod_v;
    logic [41:0] asid_v;
    logic [95:0] pdt_v, addr_v, data_v;
    logic [2:0]  busy, gnt, valid;
    logic [31:0] rdata;
    logic        ldst_use, ldst_req, ldst_rw;
    logic [1:0]  ldst_order, ldst_mmumod;
    logic [13:0] ldst_asid;
    logic [31:0] ldst_pdt, ldst_addr, ldst_data;
    logic        core_busy, core_req;
    logic [31:0] core_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_control_ldst_arbiter #(.REQ_N(3), .OUTS_MAX(2)) dut (
        .iCLOCK       (clk),
        .inRESET      (rst_n),
        .iRESET_SYNC  (rsync),
        .iRQ_USE      (use_v),
        .iRQ_REQ      (req_v),
        .oRQ_BUSY     (busy),
        .oRQ_GNT      (gnt),
        .iRQ_ORDER    (order_v),
        .iRQ_RW       (rw_v),
        .iRQ_ASID     (asid_v),
        .iRQ_MMUMOD   (mmumod_v),
        .iRQ_PDT      (pdt_v),
        .iRQ_ADDR     (addr_v),
        .iRQ_DATA     (data_v),
        .oRQ_VALID    (valid),
        .oRQ_DATA     (rdata),
        .oLDST_USE    (ldst_use),
        .oLDST_REQ    (ldst_req),
        .oLDST_ORDER  (ldst_order),
        .oLDST_RW     (ldst_rw),
        .oLDST_ASID   (ldst_asid),
        .oLDST_MMUMOD (ldst_mmumod),
        .oLDST_PDT    (ldst_pdt),
        .oLDST_ADDR   (ldst_addr),
        .oLDST_DATA   (ldst_data),
        .iLDST_BUSY   (core_busy),
        .iLDST_REQ    (core_req),
        .iLDST_DATA   (core_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rsync = 1'b0;
        use_v = '0; req_v = '0; rw_v = '0; order_v = '0; mmumod_v = '0;
        asid_v = '0; pdt_v = '0; addr_v = '0; data_v = '0;
        core_busy = 1'b0; core_req = 1'b0; core_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h7);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ldst_use", 32'(ldst_use), 32'h0);
        check("rst_ldst_req", 32'(ldst_req), 32'h0);
        rst_n = 1'b1;
        tick;

        // 1: single read from requester 0
        use_v = 3'b001; order_v[1:0] = LDST_ORDER_WORD; addr_v[31:0] = 32'h100; asid_v[13:0] = 14'h5;
        tick;
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_busy", 32'(busy), 32'h6);
        req_v = 3'b001;
        #1;
        check("t1_ldst_req", 32'(ldst_req), 32'h1);
        check("t1_addr", ldst_addr, 32'h100);
        check("t1_order", 32'(ldst_order), 32'h2);
        check("t1_asid", 32'(ldst_asid), 32'h5);
        tick;
        req_v = '0;
        tick; tick;
        core_req = 1'b1; core_data = 32'hDEADBEEF;
        #1;
        check("t1_valid", 32'(valid), 32'h1);
        check("t1_rdata", rdata, 32'hDEADBEEF);
        tick;
        core_req = 1'b0; use_v = '0;
        tick;
        check("t1_idle_gnt", 32'(gnt), 32'h0);
        check("t1_idle_use", 32'(ldst_use), 32'h0);

        // 2: three simultaneous claims, one write each, rr starts at 0
        rsync = 1'b1;
        tick;
        rsync = 1'b0;
        use_v = 3'b111; rw_v = 3'b111;
        for (int i = 0; i < 3; i++) begin
            addr_v[i*32 +: 32] = 32'h200 + 32'(4 * i);
            data_v[i*32 +: 32] = 32'hA0 + 32'(i);
        end
        tick;
        for (int i = 0; i < 3; i++) begin
            check("t2_gnt", 32'(gnt), 32'(1) << i);
            req_v = 3'(1 << i);
            #1;
            check("t2_addr", ldst_addr, 32'h200 + 32'(4 * i));
            check("t2_wdata", ldst_data, 32'hA0 + 32'(i));
            check("t2_rw", 32'(ldst_rw), 32'h1);
            tick;
            req_v = '0; core_req = 1'b1; use_v[i] = 1'b0;
            #1;
            check("t2_valid", 32'(valid), 32'(1) << i);
            tick;
            core_req = 1'b0;
            check("t2_idle_gap", 32'(gnt), 32'h0);
            tick;
        end
        rw_v = '0;

        // 3: owner 1 drains two reads while requester 2 waits
        use_v = 3'b010; addr_v[63:32] = 32'h300;
        tick;
        check("t3_gnt", 32'(gnt), 32'h2);
        use_v = 3'b110; req_v = 3'b010;
        tick; tick;
        req_v = '0; use_v = 3'b100;
        tick;
        check("t3_drain_gnt", 32'(gnt), 32'h2);
        check("t3_drain_use", 32'(ldst_use), 32'h1);
        check("t3_drain_req", 32'(ldst_req), 32'h0);
        check("t3_drain_busy", 32'(busy), 32'h7);
        core_req = 1'b1;
        #1;
        check("t3_valid", 32'(valid), 32'h2);
        tick;
        core_req = 1'b0;
        tick;
        check("t3_hold", 32'(gnt), 32'h2);
        core_req = 1'b1;
        tick;
        core_req = 1'b0;
        check("t3_idle", 32'(gnt), 32'h0);
        tick;
        check("t3_next_owner", 32'(gnt), 32'h4);
        use_v = '0;
        tick;

        // 4: third read held off at OUTS_MAX
        use_v = 3'b001;
        tick;
        check("t4_gnt", 32'(gnt), 32'h1);
        req_v = 3'b001;
        tick; tick;
        check("t4_full_busy", 32'(busy), 32'h7);
        check("t4_full_req", 32'(ldst_req), 32'h0);
        tick;
        check("t4_full_busy2", 32'(busy), 32'h7);
        core_req = 1'b1;
        tick;
        core_req = 1'b0;
        #1;
        check("t4_release_busy", 32'(busy), 32'h6);
        check("t4_release_req", 32'(ldst_req), 32'h1);
        tick;
        req_v = '0;
        #1;
        check("t4_refull_busy", 32'(busy), 32'h7);
        core_req = 1'b1;
        tick; tick;
        core_req = 1'b0; use_v = '0;
        tick;
        check("t4_idle", 32'(gnt), 32'h0);

        // 5: core stall holds the command for four cycles
        use_v = 3'b010; addr_v[63:32] = 32'h500;
        tick;
        check("t5_gnt", 32'(gnt), 32'h2);
        core_busy = 1'b1; req_v = 3'b010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t5_stall_req", 32'(ldst_req), 32'h1);
            check("t5_stall_addr", ldst_addr, 32'h500);
            check("t5_stall_busy", 32'(busy), 32'h7);
            tick;
        end
        core_busy = 1'b0;
        #1;
        check("t5_go_busy", 32'(busy), 32'h5);
        tick;
        req_v = '0; use_v = '0;
        tick;
        check("t5_drain_gnt", 32'(gnt), 32'h2);
        check("t5_drain_use", 32'(ldst_use), 32'h1);
        core_req = 1'b1;
        tick;
        core_req = 1'b0;
        check("t5_single_issue", 32'(gnt), 32'h0);

        // 6: sync reset with a read outstanding, late response dropped
        use_v = 3'b001;
        tick;
        check("t6_gnt_wrap", 32'(gnt), 32'h1);
        req_v = 3'b001;
        tick;
        req_v = '0; rsync = 1'b1; use_v = '0;
        tick;
        rsync = 1'b0;
        check("t6_gnt", 32'(gnt), 32'h0);
        check("t6_use", 32'(ldst_use), 32'h0);
        check("t6_busy", 32'(busy), 32'h7);
        core_req = 1'b1; core_data = 32'h1234;
        #1;
        check("t6_late_valid", 32'(valid), 32'h0);
        tick;
        core_req = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
